// File: rtl/tlb_unit.sv
// 32-entry fully associative dual-page MIPS32 joint TLB with a TLBR/TLBWI/TLBWR/TLBP
// maintenance FSM and registered instruction-fetch and data translation ports.
module tlb_unit #(
    parameter int unsigned TLB_ENTRIES = 32,
    parameter int unsigned TLB_IDXBITS = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [31:0] cp0_index,
    input  logic [31:0] cp0_random,
    input  logic [31:0] cp0_entrylo0,
    input  logic [31:0] cp0_entrylo1,
    input  logic [11:0] cp0_mask,
    input  logic [31:0] cp0_entryhi,
    output logic        tlbr,
    output logic [31:0] tlbr_lo0,
    output logic [31:0] tlbr_lo1,
    output logic [31:0] tlbr_hi,
    output logic [11:0] tlbr_mask,
    output logic        tlbwr,
    output logic        tlbp,
    output logic [31:0] tlbp_index,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic        i_valid,
    output logic [31:0] i_paddr,
    output logic        i_miss,
    output logic        i_invalid,
    output logic [2:0]  i_c,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    input  logic        d_write,
    output logic        d_valid,
    output logic [31:0] d_paddr,
    output logic        d_miss,
    output logic        d_invalid,
    output logic        d_modified,
    output logic [2:0]  d_c
);
    localparam logic [1:0] OpR = 2'd0, OpWi = 2'd1, OpWr = 2'd2, OpP = 2'd3;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    typedef struct packed {
        logic                   hit;
        logic [TLB_IDXBITS-1:0] idx;
        logic [31:0]            paddr;
        logic [2:0]             c;
        logic                   d;
        logic                   v;
    } lookup_t;

    logic [18:0]            vpn2_q [TLB_ENTRIES];
    logic [7:0]             asid_q [TLB_ENTRIES];
    logic [11:0]            mask_q [TLB_ENTRIES];
    logic                   g_q    [TLB_ENTRIES];
    logic [19:0]            pfn_q  [TLB_ENTRIES][2];
    logic [2:0]             c_q    [TLB_ENTRIES][2];
    logic                   d_q    [TLB_ENTRIES][2];
    logic                   v_q    [TLB_ENTRIES][2];
    logic [TLB_ENTRIES-1:0] written_q;

    state_e                 state_q, state_d;
    logic [1:0]             op_q;
    logic [TLB_IDXBITS-1:0] idx_q, rnd_q, widx;
    logic [25:0]            lo_q [2];
    logic [11:0]            pmask_q;
    logic [18:0]            hvpn2_q;
    logic [7:0]             hasid_q;
    logic                   we, resp;
    lookup_t                i_res, d_res, p_res;

    // Lowest matching index wins; later matches are ignored.
    function automatic lookup_t lookup(input logic [31:0] va, input logic [7:0] asid);
        lookup_t     r;
        logic [12:0] sel;
        logic [31:0] off;
        logic        odd;
        r   = '0;
        sel = '0;
        off = '0;
        odd = 1'b0;
        for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            if (!r.hit && written_q[i] &&
                (((vpn2_q[i] ^ va[31:13]) & ~{7'b0, mask_q[i]}) == 19'b0) &&
                (g_q[i] || asid_q[i] == asid)) begin
                sel     = {mask_q[i], 1'b1} ^ {1'b0, mask_q[i]};
                odd     = |(va[24:12] & sel);
                off     = {8'b0, mask_q[i], 12'hFFF};
                r.hit   = 1'b1;
                r.idx   = i[TLB_IDXBITS-1:0];
                r.paddr = ({pfn_q[i][odd], 12'b0} & ~off) | (va & off);
                r.c     = c_q[i][odd];
                r.d     = d_q[i][odd];
                r.v     = v_q[i][odd];
            end
        end
        return r;
    endfunction

    assign i_res = lookup(i_vaddr, cp0_entryhi[7:0]);
    assign d_res = lookup(d_vaddr, cp0_entryhi[7:0]);
    assign p_res = lookup({hvpn2_q, 13'b0}, hasid_q);

    assign we       = (state_q == StExec) && (op_q == OpWi || op_q == OpWr);
    assign widx     = (op_q == OpWr) ? rnd_q : idx_q;
    assign op_ready = (state_q == StIdle);
    // Gated by resetn so a reset landing in RESP suppresses the strobe.
    assign resp     = (state_q == StResp) && resetn;
    assign tlbr     = resp && (op_q == OpR);
    assign tlbwr    = resp && (op_q == OpWr);
    assign tlbp     = resp && (op_q == OpP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (op_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn && we) begin
            vpn2_q[widx] <= hvpn2_q;
            asid_q[widx] <= hasid_q;
            mask_q[widx] <= pmask_q;
            g_q[widx]    <= lo_q[0][0] & lo_q[1][0];
            for (int p = 0; p < 2; p++) begin
                pfn_q[widx][p] <= lo_q[p][25:6];
                c_q[widx][p]   <= lo_q[p][5:3];
                d_q[widx][p]   <= lo_q[p][2];
                v_q[widx][p]   <= lo_q[p][1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            written_q  <= '0;
            tlbr_lo0   <= '0;
            tlbr_lo1   <= '0;
            tlbr_hi    <= '0;
            tlbr_mask  <= '0;
            tlbp_index <= '0;
            i_valid    <= 1'b0;
            i_paddr    <= '0;
            i_miss     <= 1'b0;
            i_invalid  <= 1'b0;
            i_c        <= '0;
            d_valid    <= 1'b0;
            d_paddr    <= '0;
            d_miss     <= 1'b0;
            d_invalid  <= 1'b0;
            d_modified <= 1'b0;
            d_c        <= '0;
        end else begin
            state_q <= state_d;
            if (op_valid && op_ready) begin
                op_q    <= op_code;
                idx_q   <= cp0_index[TLB_IDXBITS-1:0];
                rnd_q   <= cp0_random[TLB_IDXBITS-1:0];
                lo_q[0] <= cp0_entrylo0[25:0];
                lo_q[1] <= cp0_entrylo1[25:0];
                pmask_q <= cp0_mask;
                hvpn2_q <= cp0_entryhi[31:13];
                hasid_q <= cp0_entryhi[7:0];
            end
            if (we) written_q[widx] <= 1'b1;
            if (state_q == StExec && op_q == OpR) begin
                tlbr_lo0  <= {6'b0, pfn_q[idx_q][0], c_q[idx_q][0], d_q[idx_q][0],
                              v_q[idx_q][0], g_q[idx_q]};
                tlbr_lo1  <= {6'b0, pfn_q[idx_q][1], c_q[idx_q][1], d_q[idx_q][1],
                              v_q[idx_q][1], g_q[idx_q]};
                tlbr_hi   <= {vpn2_q[idx_q], 5'b0, asid_q[idx_q]};
                tlbr_mask <= mask_q[idx_q];
            end
            if (state_q == StExec && op_q == OpP) begin
                tlbp_index <= p_res.hit ? {1'b0, {(31 - TLB_IDXBITS){1'b0}}, p_res.idx}
                                        : 32'h8000_0000;
            end
            i_valid <= i_req;
            if (i_req) begin
                i_miss    <= !i_res.hit;
                i_invalid <= i_res.hit && !i_res.v;
                i_paddr   <= i_res.paddr;
                i_c       <= i_res.c;
            end
            d_valid <= d_req;
            if (d_req) begin
                d_miss     <= !d_res.hit;
                d_invalid  <= d_res.hit && !d_res.v;
                d_modified <= d_res.hit && d_write && d_res.v && !d_res.d;
                d_paddr    <= d_res.paddr;
                d_c        <= d_res.c;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cp0_index[31:TLB_IDXBITS], cp0_random[31:TLB_IDXBITS],
                           cp0_entrylo0[31:26], cp0_entrylo1[31:26], cp0_entryhi[12:8],
                           i_res.idx, i_res.d, d_res.idx, p_res.paddr, p_res.c, p_res.d,
                           p_res.v};

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized self-checking bench for tlb_unit against a page-arithmetic reference model.
module tb_tlb_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0, op_ready;
    logic [1:0]  op_code = '0;
    logic [31:0] cp0_index = '0, cp0_random = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
    logic [11:0] cp0_mask = '0;
    logic [31:0] cp0_entryhi = '0;
    logic        tlbr, tlbwr, tlbp;
    logic [31:0] tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
    logic [11:0] tlbr_mask;
    logic        i_req = 1'b0, i_valid, i_miss, i_invalid;
    logic [31:0] i_vaddr = '0, i_paddr;
    logic [2:0]  i_c;
    logic        d_req = 1'b0, d_write = 1'b0, d_valid, d_miss, d_invalid, d_modified;
    logic [31:0] d_vaddr = '0, d_paddr;
    logic [2:0]  d_c;

    tlb_unit #(.TLB_ENTRIES(32), .TLB_IDXBITS(5)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .cp0_index(cp0_index), .cp0_random(cp0_random),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_mask(cp0_mask),
        .cp0_entryhi(cp0_entryhi), .tlbr(tlbr), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
        .tlbr_hi(tlbr_hi), .tlbr_mask(tlbr_mask), .tlbwr(tlbwr), .tlbp(tlbp),
        .tlbp_index(tlbp_index), .i_req(i_req), .i_vaddr(i_vaddr), .i_valid(i_valid),
        .i_paddr(i_paddr), .i_miss(i_miss), .i_invalid(i_invalid), .i_c(i_c),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_write(d_write), .d_valid(d_valid),
        .d_paddr(d_paddr), .d_miss(d_miss), .d_invalid(d_invalid),
        .d_modified(d_modified), .d_c(d_c)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference TLB contents
    logic [18:0] m_vpn2 [32];
    logic [7:0]  m_asid [32];
    logic [11:0] m_mask [32];
    bit          m_g    [32];
    bit          m_wr   [32];
    logic [19:0] m_pfn  [32][2];
    logic [2:0]  m_c    [32][2];
    bit          m_d    [32][2];
    bit          m_v    [32][2];

    logic [11:0] legal_masks [7] = '{12'h000, 12'h003, 12'h00F, 12'h03F, 12'h0FF, 12'h3FF,
                                     12'hFFF};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_lo(input logic [19:0] pfn, input logic [2:0] c,
                                          input bit d, input bit v, input bit g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

    // Bytes per page of entry e.
    function automatic longint unsigned m_ps(input int e);
        return 64'd4096 * (64'(m_mask[e]) + 64'd1);
    endfunction

    function automatic int m_find(input logic [31:0] va, input logic [7:0] asid);
        longint unsigned v, base, pair;
        v = 64'(va);
        for (int e = 0; e < 32; e++) begin
            pair = 2 * m_ps(e);
            base = 64'({m_vpn2[e], 13'b0});
            if (m_wr[e] && (v / pair == base / pair) && (m_g[e] || m_asid[e] == asid))
                return e;
        end
        return -1;
    endfunction

    task automatic m_translate(input logic [31:0] va, input logic [7:0] asid, input bit wr,
                               output bit hit, output bit inv, output bit modf,
                               output logic [31:0] pa, output logic [2:0] c);
        int e;
        int pg;
        longint unsigned ps, base, v;
        e = m_find(va, asid);
        hit = (e >= 0);
        inv = 0;
        modf = 0;
        pa = '0;
        c = '0;
        if (hit) begin
            v    = 64'(va);
            ps   = m_ps(e);
            pg   = int'((v / ps) % 2);
            base = 64'(m_pfn[e][pg]) * 4096;
            pa   = 32'(base - base % ps + v % ps);
            c    = m_c[e][pg];
            inv  = !m_v[e][pg];
            modf = wr && m_v[e][pg] && !m_d[e][pg];
        end
    endtask

    task automatic m_write(input int idx, input logic [31:0] lo0, input logic [31:0] lo1,
                           input logic [11:0] mask, input logic [31:0] hi);
        logic [31:0] lo [2];
        lo[0] = lo0;
        lo[1] = lo1;
        m_vpn2[idx] = hi[31:13];
        m_asid[idx] = hi[7:0];
        m_mask[idx] = mask;
        m_g[idx]    = lo0[0] & lo1[0];
        m_wr[idx]   = 1;
        for (int p = 0; p < 2; p++) begin
            m_pfn[idx][p] = lo[p][25:6];
            m_c[idx][p]   = lo[p][5:3];
            m_d[idx][p]   = lo[p][2];
            m_v[idx][p]   = lo[p][1];
        end
    endtask

    task automatic drive_op(input logic [1:0] code, input logic [4:0] idx,
                            input logic [4:0] rnd, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [11:0] mask,
                            input logic [31:0] hi);
        op_code      = code;
        cp0_index    = {27'($urandom), idx};
        cp0_random   = {27'($urandom), rnd};
        cp0_entrylo0 = {6'($urandom), lo0[25:0]};
        cp0_entrylo1 = {6'($urandom), lo1[25:0]};
        cp0_mask     = mask;
        cp0_entryhi  = {hi[31:13], 5'($urandom), hi[7:0]};
        op_valid     = 1'b1;
    endtask

    task automatic do_op(input logic [1:0] code, input logic [4:0] idx, input logic [4:0] rnd,
                         input logic [31:0] lo0, input logic [31:0] lo1,
                         input logic [11:0] mask, input logic [31:0] hi);
        logic [2:0]  exp_stb;
        logic [31:0] exp_p;
        int          e;
        exp_stb = (code == 2'd0) ? 3'b100 : (code == 2'd2) ? 3'b010 :
                  (code == 2'd3) ? 3'b001 : 3'b000;
        e = m_find({hi[31:13], 13'b0}, hi[7:0]);
        exp_p = (e < 0) ? 32'h8000_0000 : 32'(e);
        drive_op(code, idx, rnd, lo0, lo1, mask, hi);
        check("op_ready_idle", {31'b0, op_ready}, 1);
        tick();
        op_valid = 1'b0;
        check("exec_ready", {31'b0, op_ready}, 0);
        check("exec_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        if (code == 2'd1) m_write(int'(idx), lo0, lo1, mask, hi);
        if (code == 2'd2) m_write(int'(rnd), lo0, lo1, mask, hi);
        tick();
        check("resp_stb", {29'b0, tlbr, tlbwr, tlbp}, {29'b0, exp_stb});
        if (code == 2'd0) begin
            check("tlbr_lo0", tlbr_lo0, mk_lo(m_pfn[idx][0], m_c[idx][0], m_d[idx][0],
                                             m_v[idx][0], m_g[idx]));
            check("tlbr_lo1", tlbr_lo1, mk_lo(m_pfn[idx][1], m_c[idx][1], m_d[idx][1],
                                             m_v[idx][1], m_g[idx]));
            check("tlbr_hi", tlbr_hi, {m_vpn2[idx], 5'b0, m_asid[idx]});
            check("tlbr_mask", {20'b0, tlbr_mask}, {20'b0, m_mask[idx]});
        end
        if (code == 2'd3) check("tlbp_index", tlbp_index, exp_p);
        tick();
        check("idle_ready", {31'b0, op_ready}, 1);
        check("idle_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
    endtask

    task automatic lookup(input logic [31:0] iva, input logic [31:0] dva,
                          input logic [7:0] asid, input bit dw);
        bit          ih, ii, im, dh, di, dm;
        logic [31:0] ipa, dpa;
        logic [2:0]  ic, dc;
        m_translate(iva, asid, 1'b0, ih, ii, im, ipa, ic);
        m_translate(dva, asid, dw, dh, di, dm, dpa, dc);
        cp0_entryhi = {24'h0, asid};
        i_req = 1'b1;
        i_vaddr = iva;
        d_req = 1'b1;
        d_vaddr = dva;
        d_write = dw;
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        check("i_valid", {31'b0, i_valid}, 1);
        check("i_miss", {31'b0, i_miss}, {31'b0, !ih});
        if (ih) begin
            check("i_invalid", {31'b0, i_invalid}, {31'b0, ii});
            check("i_paddr", i_paddr, ipa);
            check("i_c", {29'b0, i_c}, {29'b0, ic});
        end
        check("d_valid", {31'b0, d_valid}, 1);
        check("d_miss", {31'b0, d_miss}, {31'b0, !dh});
        if (dh) begin
            check("d_invalid", {31'b0, d_invalid}, {31'b0, di});
            check("d_modified", {31'b0, d_modified}, {31'b0, dm});
            check("d_paddr", d_paddr, dpa);
            check("d_c", {29'b0, d_c}, {29'b0, dc});
        end
        tick();
        check("valid_drop", {30'b0, i_valid, d_valid}, 0);
        if (dh) check("d_paddr_hold", d_paddr, dpa);
    endtask

    function automatic int pick_written();
        int j;
        j = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
            if (m_wr[(j + k) % 32]) return (j + k) % 32;
        end
        return j;
    endfunction

    initial begin
        logic [31:0] lo0, lo1, va, vb;
        logic [11:0] mk;
        logic [18:0] vpn2;
        bit          g0, g1;
        int          j, k;
        for (int e = 0; e < 32; e++) m_wr[e] = 0;

        // Reset state
        resetn = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'b0, op_ready}, 1);
        check("rst_valid", {30'b0, i_valid, d_valid}, 0);
        check("rst_flags", {27'b0, i_miss, d_miss, i_invalid, d_invalid, d_modified}, 0);
        check("rst_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        check("rst_tlbp_index", tlbp_index, 0);
        check("rst_tlbr_hi", tlbr_hi, 0);
        resetn = 1'b1;
        lookup(32'h0, 32'h0, 8'd0, 1'b0);
        check("empty_miss", {31'b0, d_miss}, 1);

        // Basic TLBWI and translation
        do_op(2'd1, 5'd3, 5'd0, mk_lo(20'h12345, 3'd3, 1, 1, 0),
              mk_lo(20'h54321, 3'd2, 0, 0, 0), 12'h000, 32'h0040_0005);
        lookup(32'h0040_0ABC, 32'h0040_0ABC, 8'd5, 1'b0);
        check("wi3_paddr", d_paddr, 32'h1234_5ABC);
        check("wi3_c", {29'b0, d_c}, 3);
        lookup(32'h0040_0ABC, 32'h0040_1000, 8'd5, 1'b0);
        check("wi3_odd_invalid", {31'b0, d_invalid}, 1);
        lookup(32'h0040_0ABC, 32'h0040_0ABC, 8'd6, 1'b0);
        check("asid_mismatch_miss", {31'b0, d_miss}, 1);

        // Global entry, store to clean page
        do_op(2'd1, 5'd4, 5'd0, mk_lo(20'hABCDE, 3'd2, 0, 1, 1),
              mk_lo(20'h11111, 3'd1, 1, 1, 1), 12'h000, 32'h0060_0001);
        lookup(32'h0060_0100, 32'h0060_0100, 8'd9, 1'b1);
        check("global_hit", {31'b0, d_miss}, 0);
        check("store_modified", {31'b0, d_modified}, 1);

        // 16 KB pages
        do_op(2'd1, 5'd5, 5'd0, mk_lo(20'h0AAAA, 3'd1, 1, 1, 0),
              mk_lo(20'h0BEEF, 3'd2, 1, 1, 0), 12'h003, 32'h0080_0000);
        lookup(32'h0080_2123, 32'h0080_6123, 8'd0, 1'b0);
        check("mask16k_odd_paddr", d_paddr, 32'h0BEE_E123);
        check("mask16k_odd_c", {29'b0, d_c}, 2);
        check("mask16k_even_paddr", i_paddr, 32'h0AAA_A123);

        // TLBP / TLBR
        do_op(2'd3, 5'd0, 5'd0, 32'h0, 32'h0, 12'h000, 32'h0040_0005);
        check("tlbp_hit3", tlbp_index, 32'h0000_0003);
        do_op(2'd3, 5'd0, 5'd0, 32'h0, 32'h0, 12'h000, 32'h1230_0005);
        check("tlbp_miss", tlbp_index, 32'h8000_0000);
        do_op(2'd0, 5'd3, 5'd0, 32'h0, 32'h0, 12'h000, 32'h0);
        check("tlbr3_lo0", tlbr_lo0, mk_lo(20'h12345, 3'd3, 1, 1, 0));
        check("tlbr3_hi", tlbr_hi, 32'h0040_0005);

        // TLBWR at Random=31 with op_valid held high through RESP
        lo0 = mk_lo(20'hFEDCB, 3'd4, 1, 1, 0);
        lo1 = mk_lo(20'h0000F, 3'd5, 1, 1, 0);
        drive_op(2'd2, 5'd0, 5'd31, lo0, lo1, 12'h000, 32'h7FFF_E003);
        tick();
        m_write(31, lo0, lo1, 12'h000, 32'h7FFF_E003);
        op_code = 2'd3;
        cp0_entryhi = 32'h7FFF_E003;
        check("held_exec_ready", {31'b0, op_ready}, 0);
        check("held_exec_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        tick();
        check("held_resp_ready", {31'b0, op_ready}, 0);
        check("held_resp_stb", {29'b0, tlbr, tlbwr, tlbp}, 3'b010);
        tick();
        check("held_idle_ready", {31'b0, op_ready}, 1);
        check("held_idle_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        tick();
        op_valid = 1'b0;
        check("held2_exec_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        tick();
        check("held2_resp_stb", {29'b0, tlbr, tlbwr, tlbp}, 3'b001);
        check("held2_tlbp31", tlbp_index, 32'd31);
        tick();
        check("held2_idle_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        lookup(32'h7FFF_E010, 32'h7FFF_F010, 8'd3, 1'b0);

        // Reset while in EXEC
        drive_op(2'd1, 5'd7, 5'd0, mk_lo(20'h33333, 3'd1, 1, 1, 1),
                 mk_lo(20'h44444, 3'd1, 1, 1, 1), 12'h000, 32'h0ABC_0000);
        tick();
        op_valid = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int e = 0; e < 32; e++) m_wr[e] = 0;
        check("rst_exec_ready", {31'b0, op_ready}, 1);
        check("rst_exec_stb", {29'b0, tlbr, tlbwr, tlbp}, 0);
        tick();
        check("rst_exec_stb2", {29'b0, tlbr, tlbwr, tlbp}, 0);
        lookup(32'h0040_0ABC, 32'h0ABC_0000, 8'd5, 1'b0);
        check("rst_exec_miss", {30'b0, i_miss, d_miss}, 2'b11);

        // Randomized writes, lookups and probes
        for (int it = 0; it < 60; it++) begin
            mk   = legal_masks[$urandom_range(0, 6)];
            vpn2 = {4'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
            g0   = ($urandom_range(0, 3) == 0);
            g1   = ($urandom_range(0, 3) != 0) ? g0 : !g0;
            lo0  = mk_lo(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), g0);
            lo1  = mk_lo(20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), g1);
            k    = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 0)
                do_op(2'd1, 5'(k), 5'($urandom), lo0, lo1, mk, {vpn2, 5'b0,
                      8'($urandom_range(0, 3))});
            else
                do_op(2'd2, 5'($urandom), 5'(k), lo0, lo1, mk, {vpn2, 5'b0,
                      8'($urandom_range(0, 3))});
            for (int l = 0; l < 3; l++) begin
                j  = pick_written();
                va = {m_vpn2[j], 13'b0} ^ (32'($urandom) & 32'(2 * m_ps(j) - 1));
                j  = pick_written();
                vb = {m_vpn2[j], 13'b0} ^ (32'($urandom) & 32'(2 * m_ps(j) - 1));
                if ($urandom_range(0, 5) == 0) vb = $urandom;
                lookup(va, vb, 8'($urandom_range(0, 3)), 1'($urandom));
            end
            j = pick_written();
            do_op(2'd3, 5'd0, 5'd0, 32'h0, 32'h0, 12'h000,
                  {m_vpn2[j], 5'b0, 8'($urandom_range(0, 3))});
            if ($urandom_range(0, 2) == 0) do_op(2'd0, 5'(pick_written()), 5'd0, 32'h0, 32'h0,
                                                 12'h000, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
